reg_writeback_queue: RTL and testbench
======================================

# reg_writeback_queue

Writeback stage that drives the register file's single write port. It merges single-cycle ALU results with long-latency results (loads, multiply/divide) through a small in-order FIFO. It also keeps a pending-register scoreboard so decode can stall on registers awaiting a long-latency result. It sits between execute/memory and the register file; its outputs connect directly to the register file `write_en`, `write_sel` and `write_data` inputs.

## Interface
- `DATA_WIDTH`, 32, register data width
- `NUM_REGS`, 16, architectural registers; register 0 is hardwired zero
- `SEL_WIDTH`, 4, register select width (log2 NUM_REGS)
- `FIFO_DEPTH`, 4, long-latency result queue entries (power of two)
- `STARVE_LIMIT`, 8, consecutive ALU-won cycles before a drain is forced

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `alu_valid`  in  1  ALU result present this cycle; cannot be back-pressured
- `alu_sel`  in  SEL_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `long_valid`  in  1  long-latency result offered
- `long_ready`  out  1  queue can accept; transfer when `long_valid && long_ready`
- `long_sel`  in  SEL_WIDTH  long-latency destination
- `long_data`  in  DATA_WIDTH  long-latency result
- `reserve_en`  in  1  decode issued a long-latency op
- `reserve_sel`  in  SEL_WIDTH  its destination register
- `pending`  out  NUM_REGS  scoreboard; bit i = register i awaits long-latency writeback
- `stall_req`  out  1  upstream must hold `alu_valid` low in this cycle
- `write_en`  out  1  to register file
- `write_sel`  out  SEL_WIDTH  to register file
- `write_data`  out  DATA_WIDTH  to register file

## Operation
- Output register is loaded every cycle, in priority order:
  - `alu_valid` → ALU result.
  - Else FIFO non-empty → FIFO head (dequeue).
  - Else `write_en` ← 0, and sel/data hold their previous values.
- Write suppression: any selected entry with sel == 0 drives `write_en` = 0. It is still consumed: dequeued, and its scoreboard bit cleared.
- Long path:
  - Every accepted long result enqueues; there is no FIFO bypass.
  - `long_ready` = !full, computed from registered count only. It does not rise in the same cycle as a dequeue from full.
- FIFO: circular buffer with wrapping read/write pointers and a count of 0..FIFO_DEPTH.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - FIFO is strictly in-order.
- Scoreboard:
  - `reserve_en` sets `pending[reserve_sel]` (ignored for sel 0).
  - Dequeue of entry sel s clears `pending[s]`.
  - Set and clear of the same register in the same cycle: set wins.
  - ALU results never touch the scoreboard.
- Starvation counter:
  - Increments when `alu_valid` is high while the FIFO is non-empty; otherwise resets to 0.
  - On reaching STARVE_LIMIT, `stall_req` is registered high for exactly one cycle and the counter resets.
  - During that cycle upstream guarantees `alu_valid` = 0, so the FIFO head drains.
- Protocol violations (simulation assertions, behaviour unspecified):
  - `alu_valid` with `pending[alu_sel]` set.
  - `alu_valid` while `stall_req` is high.
  - Long-result sel that is not pending (other than sel 0).

## Timing
- Reset (async assert, sync release) values:
  - `write_en` 0, `write_sel` 0, `write_data` 0.
  - `pending` 0, `stall_req` 0, `long_ready` 1.
  - FIFO empty, pointers 0, starve counter 0.
- ALU latency: `alu_valid` at cycle N → `write_en`/`write_sel`/`write_data` at N+1.
- Long latency: accepted at N → earliest write port at N+2, if no ALU result at N+1.
- Scoreboard:
  - `pending` updates one cycle after `reserve_en`.
  - The clear is visible one cycle after the dequeue, i.e. in the same cycle the write appears at the register file. Decode may rely on the register file's write-to-read bypass in that cycle.
- Reset mid-operation: queued results and pending bits are discarded; the upstream pipeline is flushed by the same reset.

## Test plan
- Reset, then `alu_valid` sel 3 data 0x12345678 at N → `write_en` = 1, sel 3, data 0x12345678 at N+1 only; `pending` stays 0.
- `reserve_en` sel 5, later long result sel 5 data 0xDEADBEEF with ALU idle → `pending[5]` set the cycle after reserve. Write sel 5 appears 2 cycles after acceptance; `pending[5]` clears in that same cycle.
- Fill with 4 long results while `alu_valid` is held high → `long_ready` falls after the 4th accept. Releasing ALU drains the 4 entries in order on consecutive cycles; `long_ready` returns 1 one cycle after the first dequeue.
- `alu_valid` held high continuously with 1 queued entry → `stall_req` is high for one cycle after 8 ALU-won cycles. With `alu_valid` low that cycle, the entry writes the next cycle and the counter restarts.
- Long result with sel 0 → `write_en` stays 0, entry dequeued, count decrements. Same cycle: `reserve_en` sel 7 with dequeue of sel 7 → `pending[7]` remains 1.
- Assert `rst_n` low with 3 queued entries and pending bits set → all outputs take reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Writeback bus bundle: ALU and long-latency result inputs, decode
// reservation, scoreboard/stall feedback and the register-file write port.
interface reg_writeback_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
);
    logic                  alu_valid;
    logic [SEL_WIDTH-1:0]  alu_sel;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  long_valid;
    logic                  long_ready;
    logic [SEL_WIDTH-1:0]  long_sel;
    logic [DATA_WIDTH-1:0] long_data;
    logic                  reserve_en;
    logic [SEL_WIDTH-1:0]  reserve_sel;
    logic [NUM_REGS-1:0]   pending;
    logic                  stall_req;
    logic                  write_en;
    logic [SEL_WIDTH-1:0]  write_sel;
    logic [DATA_WIDTH-1:0] write_data;

    // Upstream pipeline / decode side
    modport master (
        output alu_valid, alu_sel, alu_data,
        output long_valid, long_sel, long_data,
        output reserve_en, reserve_sel,
        input  long_ready, pending, stall_req,
        input  write_en, write_sel, write_data
    );

    // Writeback queue side
    modport slave (
        input  alu_valid, alu_sel, alu_data,
        input  long_valid, long_sel, long_data,
        input  reserve_en, reserve_sel,
        output long_ready, pending, stall_req,
        output write_en, write_sel, write_data
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register-file writeback stage: ALU results win the single write port,
// long-latency results wait in an in-order FIFO, a scoreboard tracks
// registers still waiting on a long result, and a starvation counter
// forces a drain slot when the ALU keeps the queue blocked too long.
module reg_writeback_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int SEL_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_writeback_queue_if.slave    wb
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int STV_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic [SEL_WIDTH-1:0]  fifo_sel_r  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr_r;
    logic [PTR_WIDTH-1:0]  wr_ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  long_ready_r;
    logic [NUM_REGS-1:0]   pending_r;
    logic [STV_WIDTH-1:0]  starve_cnt_r;
    logic                  stall_req_r;
    logic                  write_en_r;
    logic [SEL_WIDTH-1:0]  write_sel_r;
    logic [DATA_WIDTH-1:0] write_data_r;

    logic                  fifo_empty_s;
    logic                  enq_s;
    logic                  deq_s;
    logic [SEL_WIDTH-1:0]  head_sel_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [CNT_WIDTH-1:0]  count_next_s;
    logic [NUM_REGS-1:0]   pending_next_s;
    logic [STV_WIDTH-1:0]  starve_next_s;
    logic                  stall_next_s;

    // Queue handshake: ALU always wins, queue head drains only on idle ALU cycles
    always_comb begin
        fifo_empty_s = (count_r == CNT_WIDTH'(0));
        enq_s        = wb.long_valid && long_ready_r;
        deq_s        = !wb.alu_valid && !fifo_empty_s;
        head_sel_s   = fifo_sel_r[rd_ptr_r];
        head_data_s  = fifo_data_r[rd_ptr_r];
        if (enq_s && !deq_s) begin
            count_next_s = count_r + CNT_WIDTH'(1);
        end else if (!enq_s && deq_s) begin
            count_next_s = count_r - CNT_WIDTH'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Scoreboard update: dequeue clears, reservation sets and wins a tie; r0 never pends
    always_comb begin
        pending_next_s = pending_r;
        if (deq_s) begin
            pending_next_s[head_sel_s] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (wb.reserve_en && (wb.reserve_sel != SEL_WIDTH'(0))) begin
            pending_next_s[wb.reserve_sel] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Starvation tracking: count ALU-won cycles with a waiting entry, pulse stall at the limit
    always_comb begin
        starve_next_s = STV_WIDTH'(0);
        stall_next_s  = 1'b0;
        if (wb.alu_valid && !fifo_empty_s) begin
            if (starve_cnt_r == STV_WIDTH'(STARVE_LIMIT - 1)) begin
                starve_next_s = STV_WIDTH'(0);
                stall_next_s  = 1'b1;
            end else begin
                starve_next_s = starve_cnt_r + STV_WIDTH'(1);
                stall_next_s  = 1'b0;
            end
        end else begin
            starve_next_s = STV_WIDTH'(0);
            stall_next_s  = 1'b0;
        end
    end

    // FIFO storage, pointers, occupancy and the registered not-full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_sel_r[i]  <= SEL_WIDTH'(0);
                fifo_data_r[i] <= DATA_WIDTH'(0);
            end
            rd_ptr_r     <= PTR_WIDTH'(0);
            wr_ptr_r     <= PTR_WIDTH'(0);
            count_r      <= CNT_WIDTH'(0);
            long_ready_r <= 1'b1;
        end else begin
            if (enq_s) begin
                fifo_sel_r[wr_ptr_r]  <= wb.long_sel;
                fifo_data_r[wr_ptr_r] <= wb.long_data;
                wr_ptr_r              <= wr_ptr_r + PTR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r      <= count_next_s;
            long_ready_r <= (count_next_s != CNT_WIDTH'(FIFO_DEPTH));
        end
    end

    // Scoreboard and starvation state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= NUM_REGS'(0);
            starve_cnt_r <= STV_WIDTH'(0);
            stall_req_r  <= 1'b0;
        end else begin
            pending_r    <= pending_next_s;
            starve_cnt_r <= starve_next_s;
            stall_req_r  <= stall_next_s;
        end
    end

    // Write-port register: ALU result, else queue head, else idle holding sel/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_r   <= 1'b0;
            write_sel_r  <= SEL_WIDTH'(0);
            write_data_r <= DATA_WIDTH'(0);
        end else if (wb.alu_valid) begin
            write_en_r   <= (wb.alu_sel != SEL_WIDTH'(0));
            write_sel_r  <= wb.alu_sel;
            write_data_r <= wb.alu_data;
        end else if (deq_s) begin
            write_en_r   <= (head_sel_s != SEL_WIDTH'(0));
            write_sel_r  <= head_sel_s;
            write_data_r <= head_data_s;
        end else begin
            write_en_r   <= 1'b0;
            write_sel_r  <= write_sel_r;
            write_data_r <= write_data_r;
        end
    end

    assign wb.long_ready = long_ready_r;
    assign wb.pending    = pending_r;
    assign wb.stall_req  = stall_req_r;
    assign wb.write_en   = write_en_r;
    assign wb.write_sel  = write_sel_r;
    assign wb.write_data = write_data_r;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a queue-based reference model is
// compared against the DUT every falling edge, plus literal expectations
// at the key points of each scenario.
module tb_reg_writeback_queue;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    reg_writeback_queue_if #(.DATA_WIDTH(32), .NUM_REGS(16), .SEL_WIDTH(4)) bus ();

    reg_writeback_queue #(
        .DATA_WIDTH(32), .NUM_REGS(16), .SEL_WIDTH(4),
        .FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [35:0] q[$];
    logic [15:0] m_pend;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_data;
    logic        m_stall;
    logic        m_ready;
    int          m_starve;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend   = 16'h0000;
        m_we     = 1'b0;
        m_sel    = 4'd0;
        m_data   = 32'd0;
        m_stall  = 1'b0;
        m_ready  = 1'b1;
        m_starve = 0;
    endtask

    task automatic model_step();
        logic [35:0] head;
        bit was_nonempty;
        bit accept;
        was_nonempty = (q.size() != 0);
        accept       = bus.long_valid && m_ready;
        if (bus.alu_valid) begin
            m_we   = (bus.alu_sel != 4'd0);
            m_sel  = bus.alu_sel;
            m_data = bus.alu_data;
        end else if (was_nonempty) begin
            head   = q.pop_front();
            m_we   = (head[35:32] != 4'd0);
            m_sel  = head[35:32];
            m_data = head[31:0];
            m_pend[head[35:32]] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (bus.reserve_en && bus.reserve_sel != 4'd0) m_pend[bus.reserve_sel] = 1'b1;
        if (accept) q.push_back({bus.long_sel, bus.long_data});
        if (bus.alu_valid && was_nonempty) begin
            m_starve++;
            if (m_starve == 8) begin
                m_stall  = 1'b1;
                m_starve = 0;
            end else begin
                m_stall = 1'b0;
            end
        end else begin
            m_starve = 0;
            m_stall  = 1'b0;
        end
        m_ready = (q.size() < 4);
    endtask

    // Model advance on each rising edge, immediate discard on reset
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("mdl_write_en",   64'(bus.write_en),   64'(m_we));
                chk("mdl_write_sel",  64'(bus.write_sel),  64'(m_sel));
                chk("mdl_write_data", 64'(bus.write_data), 64'(m_data));
                chk("mdl_pending",    64'(bus.pending),    64'(m_pend));
                chk("mdl_stall_req",  64'(bus.stall_req),  64'(m_stall));
                chk("mdl_long_ready", 64'(bus.long_ready), 64'(m_ready));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_sel     = 4'd0;
        bus.alu_data    = 32'd0;
        bus.long_valid  = 1'b0;
        bus.long_sel    = 4'd0;
        bus.long_data   = 32'd0;
        bus.reserve_en  = 1'b0;
        bus.reserve_sel = 4'd0;
    endtask

    task automatic reserve(input logic [3:0] sel);
        bus.reserve_en  = 1'b1;
        bus.reserve_sel = sel;
        tick();
        bus.reserve_en  = 1'b0;
    endtask

    task automatic offer_long(input logic [3:0] sel, input logic [31:0] data);
        bus.long_valid = 1'b1;
        bus.long_sel   = sel;
        bus.long_data  = data;
        tick();
        bus.long_valid = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_write_en"},   64'(bus.write_en),   64'h0);
        chk({tag, "_write_sel"},  64'(bus.write_sel),  64'h0);
        chk({tag, "_write_data"}, 64'(bus.write_data), 64'h0);
        chk({tag, "_pending"},    64'(bus.pending),    64'h0);
        chk({tag, "_stall_req"},  64'(bus.stall_req),  64'h0);
        chk({tag, "_long_ready"}, 64'(bus.long_ready), 64'h1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU result appears on the write port one cycle later, for one cycle
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd3; bus.alu_data = 32'h12345678;
        tick();
        idle();
        chk("alu_we",   64'(bus.write_en),   64'h1);
        chk("alu_sel",  64'(bus.write_sel),  64'h3);
        chk("alu_data", 64'(bus.write_data), 64'h12345678);
        chk("alu_pend", 64'(bus.pending),    64'h0);
        tick();
        chk("alu_we_off", 64'(bus.write_en), 64'h0);

        // Reserve r5, then long result writes two cycles after acceptance
        reserve(4'd5);
        chk("rsv5_pend", 64'(bus.pending), 64'h0020);
        offer_long(4'd5, 32'hDEADBEEF);
        chk("long5_we_early", 64'(bus.write_en), 64'h0);
        tick();
        chk("long5_we",   64'(bus.write_en),   64'h1);
        chk("long5_sel",  64'(bus.write_sel),  64'h5);
        chk("long5_data", 64'(bus.write_data), 64'hDEADBEEF);
        chk("long5_pend", 64'(bus.pending),    64'h0);

        // Fill the queue behind a busy ALU, then drain in order
        reserve(4'd1); reserve(4'd2); reserve(4'd4); reserve(4'd6);
        chk("fill_pend", 64'(bus.pending), 64'h0056);
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd9; bus.alu_data = 32'h00000099;
        offer_long(4'd1, 32'hA0000001);
        offer_long(4'd2, 32'hA0000002);
        offer_long(4'd4, 32'hA0000004);
        chk("fill_ready3", 64'(bus.long_ready), 64'h1);
        offer_long(4'd6, 32'hA0000006);
        idle();
        chk("full_ready", 64'(bus.long_ready), 64'h0);
        tick();
        chk("drain1_sel",   64'(bus.write_sel),  64'h1);
        chk("drain1_data",  64'(bus.write_data), 64'hA0000001);
        chk("drain1_ready", 64'(bus.long_ready), 64'h1);
        tick();
        chk("drain2_data", 64'(bus.write_data), 64'hA0000002);
        tick();
        chk("drain3_data", 64'(bus.write_data), 64'hA0000004);
        tick();
        chk("drain4_data", 64'(bus.write_data), 64'hA0000006);
        tick();
        chk("drain_done_we",   64'(bus.write_en), 64'h0);
        chk("drain_done_pend", 64'(bus.pending),  64'h0);

        // Starvation: forced drain slot after 8 ALU-won cycles
        reserve(4'd8);
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd9; bus.alu_data = 32'h00000090;
        offer_long(4'd8, 32'h00000088);
        repeat (7) tick();
        chk("starve_stall7", 64'(bus.stall_req), 64'h0);
        tick();
        chk("starve_stall8", 64'(bus.stall_req), 64'h1);
        bus.alu_valid = 1'b0;
        tick();
        chk("starve_stall_off", 64'(bus.stall_req),  64'h0);
        chk("starve_we",        64'(bus.write_en),   64'h1);
        chk("starve_sel",       64'(bus.write_sel),  64'h8);
        chk("starve_data",      64'(bus.write_data), 64'h00000088);

        // Sel 0 entry is consumed without a write; reserve/clear tie keeps r7 pending
        reserve(4'd7);
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd9; bus.alu_data = 32'h00000091;
        offer_long(4'd0, 32'h00000055);
        offer_long(4'd7, 32'h00000077);
        idle();
        tick();
        chk("sel0_we", 64'(bus.write_en), 64'h0);
        bus.reserve_en = 1'b1; bus.reserve_sel = 4'd7;
        tick();
        idle();
        chk("tie_we",   64'(bus.write_en),   64'h1);
        chk("tie_sel",  64'(bus.write_sel),  64'h7);
        chk("tie_pend", 64'(bus.pending),    64'h0080);
        tick();
        chk("tie_empty_we", 64'(bus.write_en), 64'h0);

        // Asynchronous reset with queued entries and pending bits
        reserve(4'd10); reserve(4'd11); reserve(4'd12);
        bus.alu_valid = 1'b1; bus.alu_sel = 4'd9; bus.alu_data = 32'h00000092;
        offer_long(4'd10, 32'h0000000A);
        offer_long(4'd11, 32'h0000000B);
        offer_long(4'd12, 32'h0000000C);
        chk("pre_rst_ready", 64'(bus.long_ready), 64'h1);
        chk("pre_rst_pend",  64'(bus.pending),    64'h1C80);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        idle();
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_we",   64'(bus.write_en), 64'h0);
        chk("post_rst_pend", 64'(bus.pending),  64'h0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
